// File: rtl/digit_serial_addsub.sv
// Digit-serial add/subtract: DIGIT bits per cycle through one full-adder slice with a registered carry.
// Latency NDIG+1 cycles from accept to done; start is ignored while busy, so the issue interval is NDIG+1.
module digit_serial_addsub #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             v,
    output logic             n,
    output logic             z
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = $clog2(NDIG + 1);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_msba;
    logic             r_msbb;
    logic [DIGIT:0]   w_dsum;
    logic [WIDTH-1:0] w_acc_nxt;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == LAST) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_accept    = start;
                w_state_nxt = start ? S_RUN : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);

    assign w_dsum = {1'b0, r_opa[DIGIT-1:0]} + {1'b0, r_opb[DIGIT-1:0]}
                  + {{DIGIT{1'b0}}, r_carry};

    // The new digit enters at the top, so after NDIG steps digit 0 sits at the bottom.
    generate
        if (NDIG == 1) begin : g_single
            assign w_acc_nxt = w_dsum[DIGIT-1:0];
        end else begin : g_multi
            assign w_acc_nxt = {w_dsum[DIGIT-1:0], r_acc[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_opa   <= '0;
            r_opb   <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_msba  <= 1'b0;
            r_msbb  <= 1'b0;
            result  <= '0;
            c_out   <= 1'b0;
            v       <= 1'b0;
            n       <= 1'b0;
            z       <= 1'b0;
        end else if (w_accept) begin
            r_opa   <= a;
            r_opb   <= sub ? ~b : b;
            r_carry <= sub;
            r_cnt   <= '0;
            r_msba  <= a[WIDTH-1];
            r_msbb  <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
        end else if (busy) begin
            r_opa   <= r_opa >> DIGIT;
            r_opb   <= r_opb >> DIGIT;
            r_acc   <= w_acc_nxt;
            r_carry <= w_dsum[DIGIT];
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                result <= w_acc_nxt;
                c_out  <= w_dsum[DIGIT];
                v      <= (r_msba == r_msbb) && (w_acc_nxt[WIDTH-1] != r_msba);
                n      <= w_acc_nxt[WIDTH-1];
                z      <= (w_acc_nxt == '0);
            end
        end
    end
endmodule
